// File: rtl/deser_pkg.sv
// deser_pkg
//   Shared types and sizing helpers for the deser_frame_sync deframer.
//   - deser_state_e           : framing state (HUNT / PAYLOAD / CHECK)
//   - DESER_SYNC_WORD_DEFAULT : default sync pattern (low SYNC_W bits are used)
//   - deser_shreg_w()         : shift-register width, max(WORD_W, SYNC_W)
//   - deser_bit_cnt_w()       : bit counter width, clog2(max(WORD_W, SYNC_W)+1)
//   - deser_miss_cnt_w()      : miss counter width, clog2(MISS_MAX+1)
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } deser_state_e;

  localparam logic [31:0] DESER_SYNC_WORD_DEFAULT = 32'h0000_00A5;

  function automatic int deser_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int deser_shreg_w(input int word_w, input int sync_w);
    return deser_max(word_w, sync_w);
  endfunction

  function automatic int deser_bit_cnt_w(input int word_w, input int sync_w);
    return $clog2(deser_max(word_w, sync_w) + 1);
  endfunction

  function automatic int deser_miss_cnt_w(input int miss_max);
    return $clog2(miss_max + 1);
  endfunction

endpackage

// File: rtl/deser_bit_strobe.sv
// deser_bit_strobe
//   Free-running sample counter (0 .. SAMPLE-1) and bit decision strobe.
//   Optional feature macro: DESER_MAJORITY_EN
//     undefined : bit_o = ser_i, bit_stb_o at sample_cnt == SAMPLE_PHASE
//     defined   : bit_o = majority of ser_i at SAMPLE_PHASE-1/SAMPLE_PHASE/
//                 SAMPLE_PHASE+1, bit_stb_o at sample_cnt == SAMPLE_PHASE+1
// Ports
//   clk       in   sample clock
//   rst_n     in   asynchronous active-low reset
//   ser_i     in   serial decision stream
//   bit_stb_o out  one-cycle strobe, bit_o is valid while high
//   bit_o     out  decided bit
module deser_bit_strobe #(
  parameter int SAMPLE       = 100,
  parameter int SAMPLE_PHASE = 97
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ser_i,
  output logic bit_stb_o,
  output logic bit_o
);

  localparam int CW = $clog2(SAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);

  logic [CW-1:0] sample_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
    end else if (sample_cnt_q == CNT_LAST) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_q + 1'b1;
    end
  end

`ifdef DESER_MAJORITY_EN
  localparam logic [CW-1:0] EARLY_AT = CW'(SAMPLE_PHASE - 1);
  localparam logic [CW-1:0] MID_AT   = CW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] STB_AT   = CW'(SAMPLE_PHASE + 1);

  logic early_q;
  logic mid_q;

  // The late sample is taken live on the strobe cycle, so only two taps
  // need storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_q <= 1'b0;
      mid_q   <= 1'b0;
    end else begin
      if (sample_cnt_q == EARLY_AT) early_q <= ser_i;
      if (sample_cnt_q == MID_AT)   mid_q   <= ser_i;
    end
  end

  assign bit_o     = (early_q & mid_q) | (early_q & ser_i) | (mid_q & ser_i);
  assign bit_stb_o = (sample_cnt_q == STB_AT);
`else
  localparam logic [CW-1:0] STB_AT = CW'(SAMPLE_PHASE);

  assign bit_o     = ser_i;
  assign bit_stb_o = (sample_cnt_q == STB_AT);
`endif

endmodule

// File: rtl/deser_frame_sync.sv
// deser_frame_sync
//   Serial-to-parallel deframer: decides bits from an oversampled stream,
//   hunts for SYNC_WORD, then emits each WORD_W-bit payload with a one-cycle
//   valid strobe while checking the sync word between payloads. Lock is held
//   through up to MISS_MAX-1 consecutive sync misses (flywheel).
//   Optional feature macro: DESER_MAJORITY_EN (3-sample majority decision,
//   see deser_bit_strobe; all latencies move one sample later).
// Ports
//   clk          in   sample clock, one sample per cycle
//   rst_n        in   asynchronous active-low reset
//   ser_i        in   demodulated serial decision stream
//   para_o       out  last complete payload word, MSB = first received bit
//   para_valid_o out  one-cycle pulse when para_o updates
//   locked_o     out  high while frame-aligned
//   sync_err_o   out  one-cycle pulse on each sync mismatch while locked
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | not aligned; test every bit for the sync word
// PAYLOAD | aligned; collecting WORD_W payload bits
// CHECK   | aligned; collecting SYNC_W bits, then verify the sync word
module deser_frame_sync
  import deser_pkg::*;
#(
  parameter int                SAMPLE       = 100,
  parameter int                SAMPLE_PHASE = 97,
  parameter int                WORD_W       = 40,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = DESER_SYNC_WORD_DEFAULT[SYNC_W-1:0],
  parameter int                MISS_MAX     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_i,
  output logic [WORD_W-1:0] para_o,
  output logic              para_valid_o,
  output logic              locked_o,
  output logic              sync_err_o
);

  localparam int SR_W = deser_shreg_w(WORD_W, SYNC_W);
  localparam int BCW  = deser_bit_cnt_w(WORD_W, SYNC_W);
  localparam int MCW  = deser_miss_cnt_w(MISS_MAX);

  localparam logic [BCW-1:0] WORD_LAST = BCW'(WORD_W - 1);
  localparam logic [BCW-1:0] SYNC_LAST = BCW'(SYNC_W - 1);
  localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_MAX - 1);

  logic bit_stb;
  logic bit_val;

  deser_bit_strobe #(
    .SAMPLE       (SAMPLE),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_bit_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_i     (ser_i),
    .bit_stb_o (bit_stb),
    .bit_o     (bit_val)
  );

  deser_state_e      state_q;
  logic [SR_W-1:0]   shreg_q;
  logic [SR_W-1:0]   shreg_d;
  logic [BCW-1:0]    bit_cnt_q;
  logic [MCW-1:0]    miss_cnt_q;
  logic [WORD_W-1:0] para_q;
  logic              para_valid_q;
  logic              locked_q;
  logic              sync_err_q;
  logic              sync_hit;

  // Compare against the register contents including the bit arriving on
  // this strobe, so decisions land on the same edge that captures the bit.
  assign shreg_d  = {shreg_q[SR_W-2:0], bit_val};
  assign sync_hit = (shreg_d[SYNC_W-1:0] == SYNC_WORD);

  // The oldest bit is shifted out and never inspected.
  logic unused_shreg_msb;
  assign unused_shreg_msb = shreg_q[SR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      para_q       <= '0;
      para_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      para_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (bit_stb) begin
        shreg_q <= shreg_d;
        case (state_q)
          HUNT: begin
            if (sync_hit) begin
              state_q    <= PAYLOAD;
              bit_cnt_q  <= '0;
              miss_cnt_q <= '0;
              locked_q   <= 1'b1;
            end
          end
          PAYLOAD: begin
            if (bit_cnt_q == WORD_LAST) begin
              state_q      <= CHECK;
              bit_cnt_q    <= '0;
              para_q       <= shreg_d[WORD_W-1:0];
              para_valid_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          CHECK: begin
            if (bit_cnt_q == SYNC_LAST) begin
              bit_cnt_q <= '0;
              if (sync_hit) begin
                miss_cnt_q <= '0;
                state_q    <= PAYLOAD;
              end else begin
                sync_err_q <= 1'b1;
                if (miss_cnt_q == MISS_LAST) begin
                  miss_cnt_q <= '0;
                  state_q    <= HUNT;
                  locked_q   <= 1'b0;
                end else begin
                  // Flywheel: keep the frame timing through a bad sync.
                  miss_cnt_q <= miss_cnt_q + 1'b1;
                  state_q    <= PAYLOAD;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign para_o       = para_q;
  assign para_valid_o = para_valid_q;
  assign locked_o     = locked_q;
  assign sync_err_o   = sync_err_q;

endmodule

// File: doc/deser_frame_sync.md
# deser_frame_sync

Parametrised serial-to-parallel deframer for the QPSK demodulator output. It recovers bit decisions from an oversampled serial stream at a configurable sample phase. It acquires frame alignment by searching for a sync word, then emits each WORD_W-bit payload as a parallel word with a one-cycle valid strobe. It tracks lock with a flywheel miss counter. It sits between the demodulator's decision output and the downstream word consumer.

## Interface
- SAMPLE, 100: clock cycles (samples) per bit; ≥ 4.
- SAMPLE_PHASE, 97: sample_cnt value at which a bit is decided; 1 … SAMPLE-2.
- WORD_W, 40: payload bits per frame; ≥ 2.
- SYNC_W, 8: sync word length; 2 … 32.
- SYNC_WORD, 8'hA5: expected sync pattern, MSB received first.
- MISS_MAX, 3: consecutive sync mismatches tolerated before loss of lock; ≥ 1.
- clk  in  1  sample clock, one sample per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- ser_i  in  1  demodulated serial decision stream.
- para_o  out  WORD_W  last complete payload word; MSB = first received bit.
- para_valid_o  out  1  one-cycle pulse when para_o updates.
- locked_o  out  1  high while frame-aligned.
- sync_err_o  out  1  one-cycle pulse on each sync mismatch while locked.

## Operation
- sample_cnt free-runs 0 … SAMPLE-1 and wraps. bit_stb asserts for one cycle when sample_cnt == SAMPLE_PHASE.
- On bit_stb, the decided bit shifts into the shift register's LSB. The shift register holds max(WORD_W, SYNC_W) bits.
- States:
  - HUNT: locked_o=0. On each bit_stb, compare the last SYNC_W bits to SYNC_WORD. On a match, go to PAYLOAD with bit_cnt=0 and miss_cnt=0.
  - PAYLOAD: locked_o=1. Count bit_stb. On the WORD_W-th bit, go to CHECK with bit_cnt=0 and set the word-ready flag.
  - CHECK: locked_o=1. Count SYNC_W bits. On the SYNC_W-th bit, compare the last SYNC_W bits to SYNC_WORD:
    - Match: clear miss_cnt, go to PAYLOAD.
    - Mismatch: pulse sync_err_o and increment miss_cnt. If miss_cnt reaches MISS_MAX, go to HUNT and clear miss_cnt. Otherwise go to PAYLOAD (flywheel: keep timing).
- The payload is emitted even on the frame whose following sync check fails.
- para_o holds its value between updates. It is never cleared except by reset.
- bit_cnt width is clog2(max(WORD_W, SYNC_W)+1). miss_cnt width is clog2(MISS_MAX+1). Neither counter saturates past its terminal value.
- Reset mid-frame discards the partial word and returns to HUNT.
- No output glitches on reset release. The first possible lock is SYNC_W bits after reset.

## Timing
- Reset values: para_o=0, para_valid_o=0, locked_o=0, sync_err_o=0, sample_cnt=0, state=HUNT, shift register=0.
- Latency from the bit_stb that captures the last payload bit:
  - para_o and para_valid_o update 1 cycle later.
  - The HUNT→PAYLOAD transition and locked_o rise 1 cycle after the matching bit_stb.
- sync_err_o pulses 1 cycle after the CHECK-ending bit_stb.
- locked_o falls in the same cycle as sync_err_o on the MISS_MAX-th miss.
- Frame period when locked: (WORD_W+SYNC_W)×SAMPLE cycles.
- para_valid_o never asserts on two consecutive cycles.

## Configuration
- DESER_MAJORITY_EN defined:
  - Bit decision = majority of ser_i at sample_cnt = SAMPLE_PHASE-1, SAMPLE_PHASE and SAMPLE_PHASE+1.
  - bit_stb moves to SAMPLE_PHASE+1.
  - Every latency above shifts 1 cycle later relative to sample_cnt.
- DESER_MAJORITY_EN undefined: single sample of ser_i at SAMPLE_PHASE.

## Structure
- Package deser_pkg holds:
  - State enum {HUNT, PAYLOAD, CHECK}.
  - Localparam helpers for the shift-register width and counter widths (clog2 of max).
  - Default SYNC_WORD constant.
- One sub-module, deser_bit_strobe: sample counter, bit_stb generation, and the optional majority voter. Its outputs are bit_stb and bit_o.

## Test plan
All scenarios use SAMPLE=4, SAMPLE_PHASE=1, WORD_W=8, SYNC_W=8, SYNC_WORD=8'hA5, MISS_MAX=2.
- Acquire: send random bits, then A5, 3C, A5, C3 → locked_o rises 1 cycle after the A5 bit_stb. para_o=8'h3C with a one-cycle valid pulse, then para_o=8'hC3.
- False-match immunity before lock: send 8'h5A, 8'hA4 → no lock, no valid.
- Flywheel: while locked, send sync 8'hA4 once, then a good A5 → one sync_err_o pulse, locked_o stays 1, next payload delivered, miss_cnt cleared.
- Loss of lock: send two consecutive bad syncs → two sync_err_o pulses, locked_o falls on the second. Then A5 + 8'h11 → relock, para_o=8'h11.
- Reset mid-payload: assert rst_n low after 4 payload bits → all outputs 0 immediately, state HUNT, no valid after release until a fresh A5.
- With DESER_MAJORITY_EN: inject a single-sample glitch at SAMPLE_PHASE on each bit of payload 8'hF0 → para_o=8'hF0 and valid is 1 cycle later than the non-macro build.
